// File: rtl/cpu_clk_ctrl_if.sv
// Control and status bundle between the board-level controller and cpu_clk_ctrl.
// The master side selects the mode, loads the divisor and carries the raw step
// button; the slave side returns the core enable, core reset and tick counter.
interface cpu_clk_ctrl_if #(
    parameter int DIV_WIDTH  = 32,
    parameter int TICK_WIDTH = 6
);
    logic [1:0]            mode;
    logic [DIV_WIDTH-1:0]  div_value;
    logic                  div_load;
    logic                  step_btn;
    logic                  cpu_en;
    logic                  cpu_resetn;
    logic [TICK_WIDTH-1:0] tick_count;

    modport master (
        output mode, div_value, div_load, step_btn,
        input  cpu_en, cpu_resetn, tick_count
    );

    modport slave (
        input  mode, div_value, div_load, step_btn,
        output cpu_en, cpu_resetn, tick_count
    );
endinterface

// File: rtl/cpu_clk_ctrl.sv
// Core clock-enable and reset sequencer.
// Produces a one-cycle enable pulse for a core clocked directly from clk, plus a
// sequenced core reset. Modes: halt, divided run, debounced single-step, full
// speed. The divisor is loadable at runtime and post-reset pulses are counted
// for debug LEDs.
module cpu_clk_ctrl #(
    parameter int DIV_WIDTH       = 32,
    parameter int DEFAULT_DIV     = 27000000,
    parameter int POR_CYCLES      = 16,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int TICK_WIDTH      = 6
) (
    input  logic          clk,
    input  logic          resetn,
    cpu_clk_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        MODE_HALT    = 2'b00,
        MODE_RUN_DIV = 2'b01,
        MODE_STEP    = 2'b10,
        MODE_FULL    = 2'b11
    } mode_e;

    localparam int POR_W = $clog2(POR_CYCLES + 1);
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [POR_W-1:0]     POR_LAST  = POR_W'(POR_CYCLES - 1);
    localparam logic [DEB_W-1:0]     DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_WIDTH-1:0] DIV_RESET = DIV_WIDTH'(DEFAULT_DIV);

    mode_e                 mode_now;
    mode_e                 prev_mode_q, prev_mode_d;
    logic [POR_W-1:0]      por_cnt_q, por_cnt_d;
    logic                  cpu_resetn_q, cpu_resetn_d;
    logic                  cpu_en_q, cpu_en_d;
    logic [TICK_WIDTH-1:0] tick_q, tick_d;
    logic [DIV_WIDTH-1:0]  div_reg_q, div_reg_d;
    logic [DIV_WIDTH-1:0]  div_cnt_q, div_cnt_d;
    logic                  sync1_q, sync1_d;
    logic                  sync2_q, sync2_d;
    logic                  stable_q, stable_d;
    logic [DEB_W-1:0]      deb_cnt_q, deb_cnt_d;
    logic                  step_pulse_q, step_pulse_d;
    logic                  mode_changed;
    logic                  div_wrap;

    assign mode_now     = mode_e'(bus.mode);
    assign mode_changed = (mode_now != prev_mode_q);
    // A divisor of 0 or 1 wraps every cycle, which gives a continuous enable
    assign div_wrap     = (div_reg_q <= DIV_WIDTH'(1)) ||
                          (div_cnt_q == div_reg_q - DIV_WIDTH'(1));

    assign bus.cpu_en     = cpu_en_q;
    assign bus.cpu_resetn = cpu_resetn_q;
    assign bus.tick_count = tick_q;

    // State register; a reset in the middle of operation aborts POR and debounce alike
    always_ff @(posedge clk) begin
        if (!resetn) begin
            prev_mode_q  <= mode_now;
            por_cnt_q    <= '0;
            cpu_resetn_q <= 1'b0;
            cpu_en_q     <= 1'b0;
            tick_q       <= '0;
            div_reg_q    <= DIV_RESET;
            div_cnt_q    <= '0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            deb_cnt_q    <= '0;
            step_pulse_q <= 1'b0;
        end else begin
            prev_mode_q  <= prev_mode_d;
            por_cnt_q    <= por_cnt_d;
            cpu_resetn_q <= cpu_resetn_d;
            cpu_en_q     <= cpu_en_d;
            tick_q       <= tick_d;
            div_reg_q    <= div_reg_d;
            div_cnt_q    <= div_cnt_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            deb_cnt_q    <= deb_cnt_d;
            step_pulse_q <= step_pulse_d;
        end
    end

    // Synchronise the button and accept a new level only after it has held steady
    always_comb begin
        sync1_d      = bus.step_btn;
        sync2_d      = sync1_q;
        stable_d     = stable_q;
        deb_cnt_d    = '0;
        step_pulse_d = 1'b0;
        if (sync2_q != stable_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                stable_d     = sync2_q;
                step_pulse_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    // Hold the core in reset for the power-on window after resetn is released
    always_comb begin
        por_cnt_d    = por_cnt_q;
        cpu_resetn_d = cpu_resetn_q;
        if (!cpu_resetn_q) begin
            por_cnt_d    = por_cnt_q + POR_W'(1);
            cpu_resetn_d = (por_cnt_q == POR_LAST);
        end
    end

    // Pick this cycle's enable from POR state, mode changes, divisor loads and the mode
    always_comb begin
        prev_mode_d = mode_now;
        div_reg_d   = div_reg_q;
        div_cnt_d   = div_cnt_q;
        cpu_en_d    = 1'b0;
        tick_d      = tick_q;
        if (bus.div_load) begin
            div_reg_d = bus.div_value;
            div_cnt_d = '0;
        end
        if (mode_changed) begin
            div_cnt_d = '0;
        end
        if (!cpu_resetn_d) begin
            cpu_en_d = 1'b1;
        end else if (!(mode_changed || bus.div_load)) begin
            case (mode_now)
                MODE_HALT:    cpu_en_d = 1'b0;
                MODE_RUN_DIV: begin
                    cpu_en_d  = div_wrap;
                    div_cnt_d = div_wrap ? '0 : div_cnt_q + DIV_WIDTH'(1);
                end
                MODE_STEP:    cpu_en_d = step_pulse_q;
                MODE_FULL:    cpu_en_d = 1'b1;
            endcase
        end
        if (cpu_resetn_d && cpu_en_d) begin
            tick_d = tick_q + TICK_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl with small parameters so that POR,
// division, debounce and tick wrap all happen within a few hundred cycles.
module tb_cpu_clk_ctrl;

    localparam int DIV_WIDTH       = 32;
    localparam int DEFAULT_DIV     = 4;
    localparam int POR_CYCLES      = 3;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int TICK_WIDTH      = 4;

    logic clk;
    logic resetn;

    cpu_clk_ctrl_if #(.DIV_WIDTH(DIV_WIDTH), .TICK_WIDTH(TICK_WIDTH)) bus ();

    cpu_clk_ctrl #(
        .DIV_WIDTH      (DIV_WIDTH),
        .DEFAULT_DIV    (DEFAULT_DIV),
        .POR_CYCLES     (POR_CYCLES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .TICK_WIDTH     (TICK_WIDTH)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state, expressed in terms of elapsed edges and run ages
    int       mPorEdges, mDiv, mRunAge, mDiffRun;
    bit       mS1, mS2, mStable, mPending, mRstn, mEn;
    bit [1:0] mPrevMode;
    bit [3:0] mTick;

    // Advance the reference model by one rising edge using the inputs now applied
    task automatic model_step();
        bit changed, newPending;
        int eff;
        if (!resetn) begin
            mRstn = 0; mEn = 0; mTick = 0; mPorEdges = 0; mDiv = DEFAULT_DIV;
            mRunAge = 0; mS1 = 0; mS2 = 0; mStable = 0; mDiffRun = 0; mPending = 0;
            mPrevMode = bus.mode;
            return;
        end
        newPending = 0;
        if (mS2 != mStable) begin
            mDiffRun++;
            if (mDiffRun == DEBOUNCE_CYCLES) begin
                mStable    = mS2;
                mDiffRun   = 0;
                newPending = mStable;
            end
        end else begin
            mDiffRun = 0;
        end
        mS2 = mS1;
        mS1 = bus.step_btn;
        changed   = (bus.mode != mPrevMode);
        mPrevMode = bus.mode;
        if (mPorEdges < POR_CYCLES) mPorEdges++;
        mRstn = (mPorEdges >= POR_CYCLES);
        if (bus.div_load) begin
            mDiv    = int'(bus.div_value);
            mRunAge = 0;
        end
        if (changed) mRunAge = 0;
        if (!mRstn) begin
            mEn = 1;
        end else if (changed || bus.div_load) begin
            mEn = 0;
        end else begin
            case (bus.mode)
                2'b00: mEn = 0;
                2'b01: begin
                    mRunAge++;
                    eff = (mDiv <= 1) ? 1 : mDiv;
                    mEn = ((mRunAge % eff) == 0);
                end
                2'b10: mEn = mPending;
                default: mEn = 1;
            endcase
        end
        mPending = newPending;
        if (mRstn && mEn) mTick++;
    endtask

    // One clock edge: update the model, then sample 1 ns after the edge
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Reset hold and the power-on sequence that follows release
    task automatic test_reset();
        resetn = 0;
        bus.mode = 2'b00;
        for (int i = 0; i < 5; i++) begin
            cycle();
            vectors++;
            if ({bus.cpu_resetn, bus.cpu_en, bus.tick_count} !== 6'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_hold cyc=%0d got rstn=%b en=%b tick=%0d expected 0/0/0",
                         i, bus.cpu_resetn, bus.cpu_en, bus.tick_count);
            end
        end
        resetn = 1;
        for (int e = 1; e <= 6; e++) begin
            cycle();
            vectors++;
            if (bus.cpu_resetn !== (e >= 3) || bus.cpu_en !== (e < 3) || bus.tick_count !== 4'd0) begin
                miscompares++;
                $display("[TB] FAIL por_seq edge=%0d got rstn=%b en=%b tick=%0d expected rstn=%b en=%b tick=0",
                         e, bus.cpu_resetn, bus.cpu_en, bus.tick_count, (e >= 3), (e < 3));
            end
        end
    endtask

    // Divided run with the default divisor, then reloads of 2 and 0
    task automatic test_run_div();
        int pulses = 0;
        int last   = -1;
        bus.mode = 2'b01;
        for (int i = 0; i < 80; i++) begin
            cycle();
            vectors++;
            if ({bus.cpu_resetn, bus.cpu_en, bus.tick_count} !== {mRstn, mEn, mTick}) begin
                miscompares++;
                $display("[TB] FAIL model_run i=%0d got %b/%b/%0d expected %b/%b/%0d",
                         i, bus.cpu_resetn, bus.cpu_en, bus.tick_count, mRstn, mEn, mTick);
            end
            if (bus.cpu_en === 1'b1) begin
                if (pulses > 0) begin
                    vectors++;
                    if (i - last != 4) begin
                        miscompares++;
                        $display("[TB] FAIL run_div_period got %0d expected 4", i - last);
                    end
                end
                last = i;
                pulses++;
                if (pulses == 16) begin
                    vectors++;
                    if (bus.tick_count !== 4'd0) begin
                        miscompares++;
                        $display("[TB] FAIL tick_wrap got %0d expected 0", bus.tick_count);
                    end
                end
            end
        end
        vectors++;
        if (pulses != 19) begin
            miscompares++;
            $display("[TB] FAIL run_div_count got %0d expected 19", pulses);
        end
        bus.div_value = 2;
        bus.div_load  = 1;
        for (int k = 0; k <= 8; k++) begin
            cycle();
            bus.div_load = 0;
            vectors++;
            if (bus.cpu_en !== (k != 0 && (k % 2) == 0) || bus.cpu_en !== mEn) begin
                miscompares++;
                $display("[TB] FAIL div2_pulse k=%0d got en=%b expected %b",
                         k, bus.cpu_en, (k != 0 && (k % 2) == 0));
            end
        end
        bus.div_value = 0;
        bus.div_load  = 1;
        for (int k = 0; k <= 10; k++) begin
            cycle();
            bus.div_load = 0;
            vectors++;
            if (bus.cpu_en !== (k != 0) || bus.tick_count !== mTick) begin
                miscompares++;
                $display("[TB] FAIL div0_cont k=%0d got en=%b tick=%0d expected en=%b tick=%0d",
                         k, bus.cpu_en, bus.tick_count, (k != 0), mTick);
            end
        end
    endtask

    // Single-step: a clean press, then a press with a bounce inside the window
    task automatic test_step();
        int pulses;
        int at;
        bus.mode = 2'b10;
        for (int i = 0; i < 6; i++) cycle();
        for (int s = 0; s < 2; s++) begin
            pulses = 0;
            at     = -1;
            for (int k = 1; k <= 38; k++) begin
                if (k <= 20) bus.step_btn = (s == 1 && k == 3) ? 1'b0 : 1'b1;
                else         bus.step_btn = 1'b0;
                cycle();
                vectors++;
                if ({bus.cpu_resetn, bus.cpu_en, bus.tick_count} !== {mRstn, mEn, mTick}) begin
                    miscompares++;
                    $display("[TB] FAIL model_step s=%0d k=%0d got %b/%b/%0d expected %b/%b/%0d",
                             s, k, bus.cpu_resetn, bus.cpu_en, bus.tick_count, mRstn, mEn, mTick);
                end
                if (bus.cpu_en === 1'b1) begin
                    pulses++;
                    at = k;
                end
            end
            vectors++;
            if (at != ((s == 0) ? 7 : 10)) begin
                miscompares++;
                $display("[TB] FAIL step_latency s=%0d got %0d expected %0d", s, at, (s == 0) ? 7 : 10);
            end
            vectors++;
            if (pulses != 1) begin
                miscompares++;
                $display("[TB] FAIL step_single s=%0d got %0d pulses expected 1", s, pulses);
            end
        end
    endtask

    // Switch RUN_DIV -> FULL -> HALT -> RUN_DIV in the middle of a divide period
    task automatic test_mode_switch();
        bit expEn;
        bus.mode      = 2'b01;
        bus.div_value = 4;
        bus.div_load  = 1;
        cycle();
        bus.div_load = 0;
        cycle();
        cycle();
        for (int phase = 0; phase < 3; phase++) begin
            bus.mode = (phase == 0) ? 2'b11 : (phase == 1) ? 2'b00 : 2'b01;
            for (int k = 0; k <= 8; k++) begin
                cycle();
                case (phase)
                    0:       expEn = (k != 0);
                    1:       expEn = 1'b0;
                    default: expEn = (k == 4 || k == 8);
                endcase
                vectors++;
                if (bus.cpu_en !== expEn || bus.tick_count !== mTick) begin
                    miscompares++;
                    $display("[TB] FAIL mode_switch phase=%0d k=%0d got en=%b tick=%0d expected en=%b tick=%0d",
                             phase, k, bus.cpu_en, bus.tick_count, expEn, mTick);
                end
            end
        end
    endtask

    // Reset during FULL once tick_count reaches 9; the POR sequence must repeat
    task automatic test_reset_mid_run();
        bit found = 0;
        bus.mode = 2'b11;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            if (bus.tick_count === 4'd9) found = 1;
        end
        vectors++;
        if (!found || mTick != 4'd9) begin
            miscompares++;
            $display("[TB] FAIL tick9_reached got dut=%0d model=%0d expected 9", bus.tick_count, mTick);
        end
        resetn = 0;
        cycle();
        resetn = 1;
        vectors++;
        if ({bus.cpu_resetn, bus.cpu_en, bus.tick_count} !== 6'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid got %b/%b/%0d expected 0/0/0",
                     bus.cpu_resetn, bus.cpu_en, bus.tick_count);
        end
        for (int e = 1; e <= 4; e++) begin
            cycle();
            vectors++;
            if (bus.cpu_resetn !== (e >= 3) || bus.cpu_en !== 1'b1 ||
                bus.tick_count !== 4'((e >= 3) ? e - 2 : 0)) begin
                miscompares++;
                $display("[TB] FAIL por_repeat edge=%0d got rstn=%b en=%b tick=%0d expected rstn=%b en=1 tick=%0d",
                         e, bus.cpu_resetn, bus.cpu_en, bus.tick_count, (e >= 3), (e >= 3) ? e - 2 : 0);
            end
        end
    endtask

    // Random modes, divisor loads, button activity and occasional resets
    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) bus.mode = 2'($urandom_range(0, 3));
            bus.div_load  = ($urandom_range(0, 29) == 0);
            bus.div_value = $urandom_range(0, 6);
            if ($urandom_range(0, 9) == 0) bus.step_btn = ~bus.step_btn;
            resetn = ($urandom_range(0, 199) != 0);
            cycle();
            vectors++;
            if ({bus.cpu_resetn, bus.cpu_en, bus.tick_count} !== {mRstn, mEn, mTick}) begin
                miscompares++;
                $display("[TB] FAIL model_random i=%0d got %b/%b/%0d expected %b/%b/%0d",
                         i, bus.cpu_resetn, bus.cpu_en, bus.tick_count, mRstn, mEn, mTick);
            end
        end
        resetn       = 1;
        bus.div_load = 0;
    endtask

    initial begin
        resetn        = 0;
        bus.mode      = 2'b00;
        bus.div_value = '0;
        bus.div_load  = 0;
        bus.step_btn  = 0;
        test_reset();
        test_run_div();
        test_step();
        test_mode_switch();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
